perf_monitor: RTL and testbench
===============================

PERF_MONITOR -- requirements
Module: perf_monitor

Interface
REQ-001 Parameter NUM_EVT, default 4, number of independent event channels (1..16).
REQ-002 Parameter CNT_W, default 32, width of every counter (8..64).
REQ-003 Parameter DEPTH, default 16, trace FIFO entries (power of 2, >=2).
REQ-004 Parameter TS_W, default 16, timestamp bits stored per trace record.
REQ-005 Derived SEL_W = $clog2(NUM_EVT+1); REC_W = TS_W+NUM_EVT+32.
REQ-006 clk  input  1  single clock; all state updates on rising edge.
REQ-007 rst  input  1  asynchronous, active-high reset.
REQ-008 freeze  input  1  when 1, counting and trace capture are suspended.
REQ-009 clr  input  1  synchronous clear of counters, flags and trace.
REQ-010 evt  input  NUM_EVT  per-cycle event strobes (stall, branch, forward, flush, ...).
REQ-011 pc  input  32  PC associated with the current cycle's events.
REQ-012 cnt_sel  input  SEL_W  counter select; NUM_EVT selects the cycle counter.
REQ-013 cnt_data  output  CNT_W  selected counter value.
REQ-014 ovf  output  NUM_EVT  sticky per-channel saturation flags.
REQ-015 tr_rd  input  1  trace pop request.
REQ-016 tr_valid  output  1  trace head record valid.
REQ-017 tr_data  output  REC_W  head record {timestamp, evt mask, pc}.
REQ-018 tr_count  output  $clog2(DEPTH)+1  current trace occupancy.
REQ-019 tr_drop  output  1  sticky flag: at least one record lost to full FIFO.

Function
REQ-020 Cycle counter SHALL increment by 1 every cycle with freeze=0, wrapping modulo 2^CNT_W.
REQ-021 Event counter i SHALL increment by 1 in each cycle with evt[i]=1 and freeze=0; all channels count independently in the same cycle.
REQ-022 An event counter at all-ones SHALL hold its value (saturate) and set ovf[i]=1 on the next increment attempt.
REQ-023 cnt_data SHALL be combinational from cnt_sel; cnt_sel > NUM_EVT SHALL yield 0.
REQ-024 clr=1 SHALL, next edge, zero all counters, ovf, tr_drop and empty the FIFO; clr overrides simultaneous events, freeze and tr_rd.
REQ-025 A trace push SHALL occur in a cycle with |evt=1, freeze=0, clr=0; record = {cycle[TS_W-1:0] pre-increment, evt, pc}.
REQ-026 FIFO SHALL be first-word fall-through: tr_valid = (tr_count!=0), tr_data = oldest record, zero when empty.
REQ-027 tr_rd=1 with tr_valid=1 SHALL pop one record at the edge; tr_rd on empty SHALL be ignored.
REQ-028 Push when full without a simultaneous pop SHALL discard the new record and set tr_drop.
REQ-029 Push and pop in the same cycle SHALL both occur when full or non-empty; tr_count unchanged.
REQ-030 freeze SHALL NOT block pops; counters and FIFO contents remain readable while frozen.
REQ-031 Pointers SHALL wrap modulo DEPTH; occupancy SHALL never exceed DEPTH.

Reset
REQ-032 rst=1 SHALL immediately force all counters, ovf, tr_drop, pointers and tr_count to 0, tr_valid=0, tr_data=0.
REQ-033 rst asserted mid-operation SHALL discard all FIFO contents; first capture occurs on the first edge after release.

Configuration
REQ-034 Macro PERF_TRACE_EN: when defined, trace FIFO and REQ-025..031 are implemented.
REQ-035 Without PERF_TRACE_EN: no FIFO storage instantiated; tr_valid, tr_data, tr_count, tr_drop SHALL be constant 0 and tr_rd ignored; counters unaffected.

Verification
REQ-036 Reset release, evt=4'b0101 for 10 cycles -> cnt_sel 0,2 read 10; 1,3 read 0; cnt_sel=4 reads 10.
REQ-037 CNT_W=8, evt[1]=1 for 300 cycles -> counter 1 = 0xFF, ovf=4'b0010; clr pulse -> all 0, ovf=0.
REQ-038 DEPTH=4, 6 event cycles no reads -> tr_count=4, tr_drop=1, head timestamp = first event's cycle.
REQ-039 Full FIFO, push with tr_rd=1 -> tr_count stays 4, oldest popped, new record at tail.
REQ-040 freeze=1 with evt=4'b1111 for 5 cycles -> counters and tr_count unchanged; pops still drain FIFO.
REQ-041 rst pulse with 3 records queued -> tr_valid=0, tr_count=0, cnt_data=0 asynchronously.

Source files
------------

// File: rtl/perf_monitor.sv
// perf_monitor
//   Pipeline performance monitor: one free-running cycle counter, NUM_EVT
//   saturating event counters with sticky overflow flags, and an optional
//   first-word fall-through trace FIFO of {timestamp, event mask, pc} records.
//
//   Optional feature macro: PERF_TRACE_EN
//     defined   -> trace FIFO is built (tr_* ports live)
//     undefined -> no trace storage; tr_valid/tr_data/tr_count/tr_drop tie to 0
//                  and tr_rd is ignored
//
//   Ports
//     clk       rising-edge clock
//     rst       asynchronous, active-high reset
//     freeze    suspends counting and trace capture (pops still allowed)
//     clr       synchronous clear of counters, flags and trace
//     evt       per-cycle event strobes, one bit per channel
//     pc        program counter captured with each trace record
//     cnt_sel   counter select; NUM_EVT selects the cycle counter
//     cnt_data  selected counter value (combinational), 0 when out of range
//     ovf       sticky per-channel saturation flags
//     tr_rd     trace pop request
//     tr_valid  trace head record valid
//     tr_data   trace head record {timestamp, evt, pc}, 0 when empty
//     tr_count  trace occupancy
//     tr_drop   sticky: a record was lost to a full FIFO
module perf_monitor #(
    parameter int unsigned NUM_EVT = 4,
    parameter int unsigned CNT_W   = 32,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned TS_W    = 16,
    localparam int unsigned SEL_W  = $clog2(NUM_EVT + 1),
    localparam int unsigned REC_W  = TS_W + NUM_EVT + 32,
    localparam int unsigned OCC_W  = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               freeze,
    input  logic               clr,
    input  logic [NUM_EVT-1:0] evt,
    input  logic [31:0]        pc,
    input  logic [SEL_W-1:0]   cnt_sel,
    output logic [CNT_W-1:0]   cnt_data,
    output logic [NUM_EVT-1:0] ovf,
    input  logic               tr_rd,
    output logic               tr_valid,
    output logic [REC_W-1:0]   tr_data,
    output logic [OCC_W-1:0]   tr_count,
    output logic               tr_drop
);

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    logic [CNT_W-1:0]   cyc_q, cyc_d;
    logic [CNT_W-1:0]   evt_cnt_q [NUM_EVT];
    logic [CNT_W-1:0]   evt_cnt_d [NUM_EVT];
    logic [NUM_EVT-1:0] ovf_q, ovf_d;

    always_comb begin
        cyc_d     = cyc_q;
        evt_cnt_d = evt_cnt_q;
        ovf_d     = ovf_q;
        if (clr) begin
            cyc_d = '0;
            ovf_d = '0;
            for (int unsigned i = 0; i < NUM_EVT; i++) begin
                evt_cnt_d[i] = '0;
            end
        end else if (!freeze) begin
            // cycle counter wraps; event counters saturate and flag instead
            cyc_d = cyc_q + CNT_W'(1);
            for (int unsigned i = 0; i < NUM_EVT; i++) begin
                if (evt[i]) begin
                    if (evt_cnt_q[i] == '1) begin
                        ovf_d[i] = 1'b1;
                    end else begin
                        evt_cnt_d[i] = evt_cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cyc_q <= '0;
            ovf_q <= '0;
            for (int unsigned i = 0; i < NUM_EVT; i++) begin
                evt_cnt_q[i] <= '0;
            end
        end else begin
            cyc_q     <= cyc_d;
            ovf_q     <= ovf_d;
            evt_cnt_q <= evt_cnt_d;
        end
    end

    // Loop compare avoids indexing the array with the wider select bus.
    always_comb begin
        cnt_data = '0;
        for (int unsigned i = 0; i < NUM_EVT; i++) begin
            if (cnt_sel == SEL_W'(i)) begin
                cnt_data = evt_cnt_q[i];
            end
        end
        if (cnt_sel == SEL_W'(NUM_EVT)) begin
            cnt_data = cyc_q;
        end
    end

    assign ovf = ovf_q;

    // ------------------------------------------------------------------
    // Trace FIFO
    // ------------------------------------------------------------------
`ifdef PERF_TRACE_EN
    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [REC_W-1:0] trace_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [OCC_W-1:0] count_q, count_d;
    logic             drop_q, drop_d;
    logic             fifo_empty, fifo_full;
    logic             push_req, do_push, do_pop;
    logic [REC_W-1:0] push_rec;

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == OCC_W'(DEPTH));
        push_req   = (|evt) && !freeze && !clr;
        do_pop     = tr_rd && !fifo_empty && !clr;
        // a full FIFO still takes a record when the head leaves this cycle
        do_push    = push_req && (!fifo_full || do_pop);
        // timestamp is the cycle count before this cycle's increment
        push_rec   = {TS_W'(cyc_q), evt, pc};

        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        drop_d   = drop_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            drop_d   = 1'b0;
        end else begin
            if (do_push) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + OCC_W'(do_push) - OCC_W'(do_pop);
            if (push_req && !do_push) begin
                drop_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            drop_q   <= drop_d;
        end
    end

    // Storage needs no reset: contents are only visible through the pointers.
    always_ff @(posedge clk) begin
        if (do_push) begin
            trace_mem[wr_ptr_q] <= push_rec;
        end
    end

    assign tr_valid = !fifo_empty;
    assign tr_data  = fifo_empty ? '0 : trace_mem[rd_ptr_q];
    assign tr_count = count_q;
    assign tr_drop  = drop_q;
`else
    logic unused_trace_inputs;
    assign unused_trace_inputs = ^{tr_rd, pc};

    assign tr_valid = 1'b0;
    assign tr_data  = '0;
    assign tr_count = '0;
    assign tr_drop  = 1'b0;
`endif

endmodule

// File: tb/tb_perf_monitor.sv
// tb_perf_monitor
//   Self-checking bench for perf_monitor (NUM_EVT=4, CNT_W=8, DEPTH=4, TS_W=8).
//   A queue-based reference model tracks counters, flags and trace records;
//   trace expectations collapse to 0 when PERF_TRACE_EN is not defined.
module tb_perf_monitor;

    localparam int unsigned NE    = 4;
    localparam int unsigned CW    = 8;
    localparam int unsigned DP    = 4;
    localparam int unsigned TW    = 8;
    localparam int unsigned SEL_W = $clog2(NE + 1);
    localparam int unsigned REC_W = TW + NE + 32;
    localparam int unsigned OCC_W = $clog2(DP) + 1;
`ifdef PERF_TRACE_EN
    localparam bit TRACE = 1'b1;
`else
    localparam bit TRACE = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             freeze;
    logic             clr;
    logic [NE-1:0]    evt;
    logic [31:0]      pc;
    logic [SEL_W-1:0] cnt_sel;
    logic [CW-1:0]    cnt_data;
    logic [NE-1:0]    ovf;
    logic             tr_rd;
    logic             tr_valid;
    logic [REC_W-1:0] tr_data;
    logic [OCC_W-1:0] tr_count;
    logic             tr_drop;

    perf_monitor #(
        .NUM_EVT(NE),
        .CNT_W  (CW),
        .DEPTH  (DP),
        .TS_W   (TW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .freeze  (freeze),
        .clr     (clr),
        .evt     (evt),
        .pc      (pc),
        .cnt_sel (cnt_sel),
        .cnt_data(cnt_data),
        .ovf     (ovf),
        .tr_rd   (tr_rd),
        .tr_valid(tr_valid),
        .tr_data (tr_data),
        .tr_count(tr_count),
        .tr_drop (tr_drop)
    );

    always #10 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- reference model ----------------
    int unsigned      m_cyc;
    int unsigned      m_cnt [NE];
    logic [NE-1:0]    m_ovf;
    logic [REC_W-1:0] m_q [$];
    bit               m_drop;

    task automatic model_reset();
        m_cyc = 0;
        for (int i = 0; i < NE; i++) m_cnt[i] = 0;
        m_ovf  = '0;
        m_drop = 1'b0;
        m_q.delete();
    endtask

    function automatic logic [CW-1:0] exp_cnt(int unsigned sel);
        if (sel < NE) return CW'(m_cnt[sel]);
        if (sel == NE) return CW'(m_cyc);
        return '0;
    endfunction

    function automatic logic [OCC_W-1:0] exp_count();
        return TRACE ? OCC_W'(m_q.size()) : '0;
    endfunction

    function automatic logic [REC_W-1:0] exp_data();
        return (TRACE && m_q.size() != 0) ? m_q[0] : '0;
    endfunction

    function automatic logic exp_drop();
        return TRACE & m_drop;
    endfunction

    // Advance the model by one clock using the inputs currently driven,
    // then let the DUT take the same edge; returns 1 time unit after it.
    task automatic step();
        logic [REC_W-1:0] rec;
        logic [REC_W-1:0] gone;
        bit do_pop;
        bit do_push;
        if (clr) begin
            model_reset();
        end else begin
            do_pop  = tr_rd && (m_q.size() != 0);
            do_push = (evt != '0) && !freeze;
            rec     = {TW'(m_cyc), evt, pc};
            if (!freeze) begin
                m_cyc = (m_cyc + 1) % (2 ** CW);
                for (int i = 0; i < NE; i++) begin
                    if (evt[i]) begin
                        if (m_cnt[i] == 2 ** CW - 1) m_ovf[i] = 1'b1;
                        else m_cnt[i] = m_cnt[i] + 1;
                    end
                end
            end
            if (do_pop) gone = m_q.pop_front();
            if (do_push) begin
                if (m_q.size() < DP) m_q.push_back(rec);
                else m_drop = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        #3;
        n_checks++;
        if (ovf !== '0) begin n_errors++; $display("FAIL reset_ovf: got %h expected 0", ovf); end
        n_checks++;
        if (tr_valid !== 1'b0) begin n_errors++; $display("FAIL reset_tr_valid: got %b expected 0", tr_valid); end
        n_checks++;
        if (tr_count !== '0) begin n_errors++; $display("FAIL reset_tr_count: got %0d expected 0", tr_count); end
        n_checks++;
        if (tr_data !== '0) begin n_errors++; $display("FAIL reset_tr_data: got %h expected 0", tr_data); end
        n_checks++;
        if (tr_drop !== 1'b0) begin n_errors++; $display("FAIL reset_tr_drop: got %b expected 0", tr_drop); end
        for (int s = 0; s < 8; s++) begin
            cnt_sel = SEL_W'(s);
            #1;
            n_checks++;
            if (cnt_data !== '0) begin n_errors++; $display("FAIL reset_cnt sel=%0d: got %h expected 0", s, cnt_data); end
        end
        @(posedge clk);
        @(posedge clk);
        #5;
        rst = 1'b0;
    endtask

    task automatic test_count_basic();
        int unsigned exp36 [8];
        exp36 = '{10, 0, 10, 0, 10, 0, 0, 0};
        evt = 4'b0101;
        repeat (10) begin
            pc = $urandom;
            step();
        end
        evt = '0;
        for (int s = 0; s < 8; s++) begin
            cnt_sel = SEL_W'(s);
            #1;
            n_checks++;
            if (cnt_data !== CW'(exp36[s])) begin
                n_errors++;
                $display("FAIL basic_cnt sel=%0d: got %0d expected %0d", s, cnt_data, exp36[s]);
            end
        end
        n_checks++;
        if (tr_count !== exp_count()) begin n_errors++; $display("FAIL basic_tr_count: got %0d expected %0d", tr_count, exp_count()); end
        n_checks++;
        if (tr_drop !== exp_drop()) begin n_errors++; $display("FAIL basic_tr_drop: got %b expected %b", tr_drop, exp_drop()); end
    endtask

    task automatic test_saturation();
        clr = 1'b1;
        step();
        clr = 1'b0;
        evt = 4'b0010;
        repeat (300) begin
            pc = $urandom;
            step();
        end
        evt = '0;
        cnt_sel = SEL_W'(1);
        #1;
        n_checks++;
        if (cnt_data !== 8'hFF) begin n_errors++; $display("FAIL sat_cnt1: got %h expected ff", cnt_data); end
        n_checks++;
        if (ovf !== 4'b0010) begin n_errors++; $display("FAIL sat_ovf: got %b expected 0010", ovf); end
        cnt_sel = SEL_W'(NE);
        #1;
        n_checks++;
        if (cnt_data !== exp_cnt(NE)) begin n_errors++; $display("FAIL sat_cycle_wrap: got %0d expected %0d", cnt_data, exp_cnt(NE)); end
        // clr dominates simultaneous events and reads
        clr = 1'b1;
        evt = 4'b1111;
        tr_rd = 1'b1;
        step();
        clr = 1'b0;
        evt = '0;
        tr_rd = 1'b0;
        for (int s = 0; s < 8; s++) begin
            cnt_sel = SEL_W'(s);
            #1;
            n_checks++;
            if (cnt_data !== '0) begin n_errors++; $display("FAIL clr_cnt sel=%0d: got %h expected 0", s, cnt_data); end
        end
        n_checks++;
        if (ovf !== '0) begin n_errors++; $display("FAIL clr_ovf: got %b expected 0", ovf); end
        n_checks++;
        if (tr_count !== '0) begin n_errors++; $display("FAIL clr_tr_count: got %0d expected 0", tr_count); end
        n_checks++;
        if (tr_drop !== 1'b0) begin n_errors++; $display("FAIL clr_tr_drop: got %b expected 0", tr_drop); end
    endtask

    task automatic test_fifo_full();
        logic [REC_W-1:0] newrec;
        clr = 1'b1;
        step();
        clr = 1'b0;
        for (int k = 0; k < 6; k++) begin
            evt = NE'($urandom_range(1, 15));
            pc  = $urandom;
            step();
        end
        evt = '0;
        n_checks++;
        if (tr_count !== OCC_W'(TRACE ? 4 : 0)) begin n_errors++; $display("FAIL full_tr_count: got %0d expected %0d", tr_count, TRACE ? 4 : 0); end
        n_checks++;
        if (tr_drop !== TRACE) begin n_errors++; $display("FAIL full_tr_drop: got %b expected %b", tr_drop, TRACE); end
        n_checks++;
        if (tr_data[REC_W-1 -: TW] !== '0) begin n_errors++; $display("FAIL full_head_ts: got %0d expected 0", tr_data[REC_W-1 -: TW]); end
        n_checks++;
        if (tr_data !== exp_data()) begin n_errors++; $display("FAIL full_head: got %h expected %h", tr_data, exp_data()); end
        // push with simultaneous pop while full
        evt    = 4'b1001;
        pc     = $urandom;
        newrec = {TW'(6), evt, pc};
        tr_rd  = 1'b1;
        step();
        evt = '0;
        n_checks++;
        if (tr_count !== OCC_W'(TRACE ? 4 : 0)) begin n_errors++; $display("FAIL pushpop_tr_count: got %0d expected %0d", tr_count, TRACE ? 4 : 0); end
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (tr_data !== exp_data()) begin n_errors++; $display("FAIL drain_head k=%0d: got %h expected %h", k, tr_data, exp_data()); end
            if (k == 3) begin
                n_checks++;
                if (tr_data !== (TRACE ? newrec : '0)) begin n_errors++; $display("FAIL tail_record: got %h expected %h", tr_data, TRACE ? newrec : '0); end
            end
            step();
        end
        tr_rd = 1'b0;
        n_checks++;
        if (tr_valid !== 1'b0) begin n_errors++; $display("FAIL drain_valid: got %b expected 0", tr_valid); end
        n_checks++;
        if (tr_data !== '0) begin n_errors++; $display("FAIL drain_data: got %h expected 0", tr_data); end
        // pop on empty is ignored
        tr_rd = 1'b1;
        step();
        tr_rd = 1'b0;
        n_checks++;
        if (tr_count !== '0) begin n_errors++; $display("FAIL empty_pop_count: got %0d expected 0", tr_count); end
    endtask

    task automatic test_freeze();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (3) begin
            evt = NE'($urandom_range(1, 15));
            pc  = $urandom;
            step();
        end
        freeze = 1'b1;
        evt    = 4'b1111;
        repeat (5) step();
        for (int s = 0; s <= NE; s++) begin
            cnt_sel = SEL_W'(s);
            #1;
            n_checks++;
            if (cnt_data !== exp_cnt(s)) begin n_errors++; $display("FAIL freeze_cnt sel=%0d: got %0d expected %0d", s, cnt_data, exp_cnt(s)); end
        end
        cnt_sel = SEL_W'(NE);
        #1;
        n_checks++;
        if (cnt_data !== 8'd3) begin n_errors++; $display("FAIL freeze_cycle: got %0d expected 3", cnt_data); end
        n_checks++;
        if (tr_count !== OCC_W'(TRACE ? 3 : 0)) begin n_errors++; $display("FAIL freeze_tr_count: got %0d expected %0d", tr_count, TRACE ? 3 : 0); end
        tr_rd = 1'b1;
        for (int k = 0; k < 3; k++) begin
            n_checks++;
            if (tr_data !== exp_data()) begin n_errors++; $display("FAIL freeze_pop_head k=%0d: got %h expected %h", k, tr_data, exp_data()); end
            step();
            n_checks++;
            if (tr_count !== OCC_W'(TRACE ? 2 - k : 0)) begin n_errors++; $display("FAIL freeze_pop_count k=%0d: got %0d expected %0d", k, tr_count, TRACE ? 2 - k : 0); end
        end
        tr_rd  = 1'b0;
        freeze = 1'b0;
        evt    = '0;
    endtask

    task automatic test_random();
        int unsigned s;
        for (int n = 0; n < 400; n++) begin
            evt    = NE'($urandom);
            pc     = $urandom;
            freeze = ($urandom_range(0, 4) == 0);
            clr    = ($urandom_range(0, 49) == 0);
            tr_rd  = $urandom_range(0, 1);
            step();
            s = $urandom_range(0, 7);
            cnt_sel = SEL_W'(s);
            #1;
            n_checks++;
            if (cnt_data !== exp_cnt(s)) begin n_errors++; $display("FAIL rnd_cnt n=%0d sel=%0d: got %h expected %h", n, s, cnt_data, exp_cnt(s)); end
            n_checks++;
            if (ovf !== m_ovf) begin n_errors++; $display("FAIL rnd_ovf n=%0d: got %b expected %b", n, ovf, m_ovf); end
            n_checks++;
            if (tr_count !== exp_count()) begin n_errors++; $display("FAIL rnd_tr_count n=%0d: got %0d expected %0d", n, tr_count, exp_count()); end
            n_checks++;
            if (tr_valid !== (exp_count() != 0)) begin n_errors++; $display("FAIL rnd_tr_valid n=%0d: got %b expected %b", n, tr_valid, exp_count() != 0); end
            n_checks++;
            if (tr_data !== exp_data()) begin n_errors++; $display("FAIL rnd_tr_data n=%0d: got %h expected %h", n, tr_data, exp_data()); end
            n_checks++;
            if (tr_drop !== exp_drop()) begin n_errors++; $display("FAIL rnd_tr_drop n=%0d: got %b expected %b", n, tr_drop, exp_drop()); end
        end
        evt    = '0;
        freeze = 1'b0;
        clr    = 1'b0;
        tr_rd  = 1'b0;
    endtask

    task automatic test_async_reset();
        clr = 1'b1;
        step();
        clr = 1'b0;
        repeat (3) begin
            evt = NE'($urandom_range(1, 15));
            pc  = $urandom;
            step();
        end
        evt = '0;
        n_checks++;
        if (tr_count !== OCC_W'(TRACE ? 3 : 0)) begin n_errors++; $display("FAIL prereset_tr_count: got %0d expected %0d", tr_count, TRACE ? 3 : 0); end
        // assert reset between edges: outputs must clear without a clock
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (tr_valid !== 1'b0) begin n_errors++; $display("FAIL arst_tr_valid: got %b expected 0", tr_valid); end
        n_checks++;
        if (tr_count !== '0) begin n_errors++; $display("FAIL arst_tr_count: got %0d expected 0", tr_count); end
        n_checks++;
        if (tr_data !== '0) begin n_errors++; $display("FAIL arst_tr_data: got %h expected 0", tr_data); end
        for (int s = 0; s <= NE; s++) begin
            cnt_sel = SEL_W'(s);
            #1;
            n_checks++;
            if (cnt_data !== '0) begin n_errors++; $display("FAIL arst_cnt sel=%0d: got %h expected 0", s, cnt_data); end
        end
        model_reset();
        @(posedge clk);
        #5;
        rst = 1'b0;
        evt = 4'b1000;
        pc  = 32'hCAFE_0001;
        step();
        evt = '0;
        n_checks++;
        if (tr_count !== OCC_W'(TRACE ? 1 : 0)) begin n_errors++; $display("FAIL post_rst_tr_count: got %0d expected %0d", tr_count, TRACE ? 1 : 0); end
        n_checks++;
        if (tr_data !== (TRACE ? {8'h00, 4'b1000, 32'hCAFE_0001} : '0)) begin
            n_errors++;
            $display("FAIL post_rst_record: got %h expected %h", tr_data, TRACE ? {8'h00, 4'b1000, 32'hCAFE_0001} : '0);
        end
        cnt_sel = SEL_W'(NE);
        #1;
        n_checks++;
        if (cnt_data !== 8'd1) begin n_errors++; $display("FAIL post_rst_cycle: got %0d expected 1", cnt_data); end
        cnt_sel = SEL_W'(3);
        #1;
        n_checks++;
        if (cnt_data !== 8'd1) begin n_errors++; $display("FAIL post_rst_cnt3: got %0d expected 1", cnt_data); end
    endtask

    initial begin
        rst     = 1'b1;
        freeze  = 1'b0;
        clr     = 1'b0;
        tr_rd   = 1'b0;
        evt     = '0;
        pc      = '0;
        cnt_sel = '0;
        model_reset();
        test_reset();
        test_count_basic();
        test_saturation();
        test_fifo_full();
        test_freeze();
        test_random();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
